// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_if
// Description : Bundle between the multi-cycle control FSM and the MIPS
//               datapath.
//               master : control FSM (drives strobes / mux selects, reads
//                        IR fields, ALU zero flag and memory ready)
//               slave  : datapath (drives IR fields, zero, mem_ready)
//               Signals:
//                 opcode, funct  IR[31:26], IR[5:0]
//                 zero           ALU equality flag (rs == rt)
//                 mem_ready      shared IM/DM access completes this cycle
//                 mem_req, pc_we, ir_we, dm_we, rf_we   strobes
//                 reg_dst, wd_sel, alu_srcb, alu_op, ext_op, pc_src  selects
//                 halted, state  status / debug
//                 cycle_cnt, instr_cnt  only when MC_CTRL_PERF_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_ctrl_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;

    logic        mem_req;
    logic        pc_we;
    logic        ir_we;
    logic        dm_we;
    logic        rf_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic [1:0]  alu_srcb;
    logic [2:0]  alu_op;
    logic        ext_op;
    logic [1:0]  pc_src;
    logic        halted;
    logic [3:0]  state;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, pc_we, ir_we, dm_we, rf_we,
        output reg_dst, wd_sel, alu_srcb, alu_op, ext_op, pc_src,
        output halted, state, cycle_cnt, instr_cnt
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, pc_we, ir_we, dm_we, rf_we,
        input  reg_dst, wd_sel, alu_srcb, alu_op, ext_op, pc_src,
        input  halted, state, cycle_cnt, instr_cnt
    );
`else
    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, pc_we, ir_we, dm_we, rf_we,
        output reg_dst, wd_sel, alu_srcb, alu_op, ext_op, pc_src,
        output halted, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, pc_we, ir_we, dm_we, rf_we,
        input  reg_dst, wd_sel, alu_srcb, alu_op, ext_op, pc_src,
        input  halted, state
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle control FSM for the MIPS datapath. Steps each
//               instruction through FETCH/DECODE/EXEC/MEM/WB and drives every
//               datapath strobe and mux select. Stalls in FETCH, MEM_RD and
//               MEM_WR until the single-port memory signals mem_ready.
//               Outputs are combinational in state, opcode, funct, zero and
//               mem_ready.
// Ports       : clk    system clock, rising edge
//               reset  asynchronous, active-low; holds the FSM in FETCH
//               bus    mc_ctrl_if.master (IR fields, flags, strobes, selects)
// Parameters  : ILLEGAL_HALT  1: unknown opcode/funct enters HALT
//                             0: unknown opcode/funct behaves as a nop
// Options     : MC_CTRL_PERF_EN  adds bus.cycle_cnt / bus.instr_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
    parameter int unsigned ILLEGAL_HALT = 1
) (
    input  wire logic clk,
    input  wire logic reset,
    mc_ctrl_if.master bus
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_EXEC_R   = 4'd2;
    localparam logic [3:0] c_EXEC_I   = 4'd3;
    localparam logic [3:0] c_MEM_ADDR = 4'd4;
    localparam logic [3:0] c_MEM_RD   = 4'd5;
    localparam logic [3:0] c_MEM_WR   = 4'd6;
    localparam logic [3:0] c_WB_R     = 4'd7;
    localparam logic [3:0] c_WB_I     = 4'd8;
    localparam logic [3:0] c_WB_MEM   = 4'd9;
    localparam logic [3:0] c_BRANCH   = 4'd10;
    localparam logic [3:0] c_JUMP     = 4'd11;
    localparam logic [3:0] c_HALT     = 4'd15;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;

    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;
    localparam logic [5:0] c_FN_NOP   = 6'b000000;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_OR   = 3'b010;
    localparam logic [2:0] c_ALU_LUI  = 3'b011;

    // Destination of an unrecognised encoding, fixed at elaboration.
    localparam logic [3:0] c_ILLEGAL_NEXT = (ILLEGAL_HALT != 0) ? c_HALT : c_FETCH;

    logic [3:0] r_state;
    logic [3:0] w_next;

    logic       w_mem_req;
    logic       w_pc_we;
    logic       w_ir_we;
    logic       w_dm_we;
    logic       w_rf_we;
    logic [1:0] w_reg_dst;
    logic [1:0] w_wd_sel;
    logic [1:0] w_alu_srcb;
    logic [2:0] w_alu_op;
    logic       w_ext_op;
    logic [1:0] w_pc_src;
    logic       w_halted;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_FETCH: begin
                if (bus.mem_ready) begin
                    w_next = c_DECODE;
                end
            end
            c_DECODE: begin
                case (bus.opcode)
                    c_OP_RTYPE: begin
                        case (bus.funct)
                            c_FN_ADDU, c_FN_SUBU: w_next = c_EXEC_R;
                            c_FN_JR:              w_next = c_JUMP;
                            c_FN_NOP:             w_next = c_FETCH;
                            default:              w_next = c_ILLEGAL_NEXT;
                        endcase
                    end
                    c_OP_ORI, c_OP_LUI: w_next = c_EXEC_I;
                    c_OP_LW, c_OP_SW:   w_next = c_MEM_ADDR;
                    c_OP_BEQ:           w_next = c_BRANCH;
                    c_OP_J, c_OP_JAL:   w_next = c_JUMP;
                    default:            w_next = c_ILLEGAL_NEXT;
                endcase
            end
            c_EXEC_R:   w_next = c_WB_R;
            c_EXEC_I:   w_next = c_WB_I;
            // Only lw and sw reach MEM_ADDR, so a single compare splits them.
            c_MEM_ADDR: w_next = (bus.opcode == c_OP_SW) ? c_MEM_WR : c_MEM_RD;
            c_MEM_RD: begin
                if (bus.mem_ready) begin
                    w_next = c_WB_MEM;
                end
            end
            c_MEM_WR: begin
                if (bus.mem_ready) begin
                    w_next = c_FETCH;
                end
            end
            c_WB_R, c_WB_I, c_WB_MEM, c_BRANCH, c_JUMP: w_next = c_FETCH;
            c_HALT:     w_next = c_HALT;
            default:    w_next = c_FETCH;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_mem_req  = 1'b0;
        w_pc_we    = 1'b0;
        w_ir_we    = 1'b0;
        w_dm_we    = 1'b0;
        w_rf_we    = 1'b0;
        w_reg_dst  = 2'b00;
        w_wd_sel   = 2'b00;
        w_alu_srcb = 2'b00;
        w_alu_op   = c_ALU_ADD;
        w_ext_op   = 1'b0;
        w_pc_src   = 2'b00;
        w_halted   = 1'b0;
        case (r_state)
            c_FETCH: begin
                // ALU computes PC+4 while the instruction word is read.
                w_mem_req  = 1'b1;
                w_alu_srcb = 2'b10;
                w_alu_op   = c_ALU_ADD;
                w_ir_we    = bus.mem_ready;
                w_pc_we    = bus.mem_ready;
            end
            c_EXEC_R, c_WB_R: begin
                // Write-back cycle keeps the ALU inputs stable so the result
                // is still valid when the GRF captures it.
                w_alu_srcb = 2'b00;
                w_alu_op   = (bus.funct == c_FN_SUBU) ? c_ALU_SUB : c_ALU_ADD;
                if (r_state == c_WB_R) begin
                    w_rf_we   = 1'b1;
                    w_reg_dst = 2'b01;
                    w_wd_sel  = 2'b00;
                end
            end
            c_EXEC_I, c_WB_I: begin
                w_alu_srcb = 2'b01;
                w_ext_op   = 1'b0;
                w_alu_op   = (bus.opcode == c_OP_LUI) ? c_ALU_LUI : c_ALU_OR;
                if (r_state == c_WB_I) begin
                    w_rf_we   = 1'b1;
                    w_reg_dst = 2'b00;
                    w_wd_sel  = 2'b00;
                end
            end
            c_MEM_ADDR, c_MEM_RD, c_MEM_WR: begin
                // Address (rs + sign-extended offset) is held for the whole
                // memory access, including wait cycles.
                w_alu_srcb = 2'b01;
                w_ext_op   = 1'b1;
                w_alu_op   = c_ALU_ADD;
                if (r_state != c_MEM_ADDR) begin
                    w_mem_req = 1'b1;
                end
                if (r_state == c_MEM_WR) begin
                    w_dm_we = bus.mem_ready;
                end
            end
            c_WB_MEM: begin
                w_rf_we   = 1'b1;
                w_reg_dst = 2'b00;
                w_wd_sel  = 2'b01;
            end
            c_BRANCH: begin
                w_alu_srcb = 2'b00;
                w_alu_op   = c_ALU_SUB;
                w_ext_op   = 1'b1;
                w_pc_src   = 2'b01;
                w_pc_we    = bus.zero;
            end
            c_JUMP: begin
                w_pc_we  = 1'b1;
                // jr is the only R-type instruction that lands in JUMP.
                w_pc_src = (bus.opcode == c_OP_RTYPE) ? 2'b11 : 2'b10;
                if (bus.opcode == c_OP_JAL) begin
                    w_rf_we   = 1'b1;
                    w_reg_dst = 2'b10;
                    w_wd_sel  = 2'b10;
                end
            end
            c_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_halted = 1'b0;
            end
        endcase
    end

    // Strobes are gated directly by reset so that an assertion in the middle
    // of an access (e.g. MEM_WR with mem_ready high) cannot leak a write.
    assign bus.mem_req  = w_mem_req & reset;
    assign bus.pc_we    = w_pc_we   & reset;
    assign bus.ir_we    = w_ir_we   & reset;
    assign bus.dm_we    = w_dm_we   & reset;
    assign bus.rf_we    = w_rf_we   & reset;
    assign bus.halted   = w_halted  & reset;
    assign bus.reg_dst  = w_reg_dst;
    assign bus.wd_sel   = w_wd_sel;
    assign bus.alu_srcb = w_alu_srcb;
    assign bus.alu_op   = w_alu_op;
    assign bus.ext_op   = w_ext_op;
    assign bus.pc_src   = w_pc_src;
    assign bus.state    = r_state;

`ifdef MC_CTRL_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------------
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt <= 32'd0;
            r_instr_cnt <= 32'd0;
        end else begin
            if (r_state != c_HALT) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            // An instruction retires (or is dropped) whenever the FSM
            // returns to FETCH from any other state.
            if ((w_next == c_FETCH) && (r_state != c_FETCH)) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
    assign bus.instr_cnt = r_instr_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Scoreboard bench for mc_ctrl. Directed per-cycle vectors set
//               the inputs and push the hand-computed expected outputs into a
//               queue; a monitor on the falling edge pops and compares. Two
//               instances share the stimulus: ILLEGAL_HALT=1 (full output
//               check) and ILLEGAL_HALT=0 (state check).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_ILL = 6'b111111;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_NOP  = 6'b000000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    always #5 clk = ~clk;

    mc_ctrl_if bus1 ();
    mc_ctrl_if bus0 ();

    assign bus1.opcode    = opcode;
    assign bus1.funct     = funct;
    assign bus1.zero      = zero;
    assign bus1.mem_ready = mem_ready;
    assign bus0.opcode    = opcode;
    assign bus0.funct     = funct;
    assign bus0.zero      = zero;
    assign bus0.mem_ready = mem_ready;

    mc_ctrl #(.ILLEGAL_HALT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    mc_ctrl #(.ILLEGAL_HALT(0)) dut_nop (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    // o = {halted, mem_req, pc_we, ir_we, dm_we, rf_we,
    //      reg_dst[2], wd_sel[2], alu_srcb[2], alu_op[3], ext_op, pc_src[2]}
    typedef struct {
        string       tag;
        logic        rst;
        logic [3:0]  s;
        logic [3:0]  s0;
        logic [17:0] o;
    } exp_t;

    exp_t  q[$];
    exp_t  e;
    string tag;
    int    checks   = 0;
    int    failures = 0;
    int    vec_no   = 0;
    logic [17:0] act;

    // One clock cycle: apply inputs, push the expected response, advance.
    task automatic v(input logic r, input logic mr, input logic z,
                     input logic [5:0] op, input logic [5:0] fn,
                     input logic [3:0] s, input logic [3:0] s0,
                     input logic h, input logic mq, input logic pw,
                     input logic iw, input logic dw, input logic rw,
                     input logic [1:0] rd, input logic [1:0] ws,
                     input logic [1:0] sb, input logic [2:0] ao,
                     input logic ex, input logic [1:0] ps);
        exp_t it;
        reset     = r;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        funct     = fn;
        it.tag = tag;
        it.rst = r;
        it.s   = s;
        it.s0  = s0;
        it.o   = {h, mq, pw, iw, dw, rw, rd, ws, sb, ao, ex, ps};
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    // FETCH with memory ready, then DECODE (with a chosen mem_ready value).
    task automatic fetch_dec(input logic [5:0] op, input logic [5:0] fn,
                             input logic dmr);
        v(1, 1,   0, op, fn, 0, 0, 0, 1, 1, 1, 0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 0, 2'd0);
        v(1, dmr, 0, op, fn, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 2'd0);
    endtask

    // Monitor / comparator.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {bus1.halted, bus1.mem_req, bus1.pc_we, bus1.ir_we,
                   bus1.dm_we, bus1.rf_we, bus1.reg_dst, bus1.wd_sel,
                   bus1.alu_srcb, bus1.alu_op, bus1.ext_op, bus1.pc_src};
            checks++;
            if ((act !== e.o) || (bus1.state !== e.s) || (bus0.state !== e.s0)) begin
                failures++;
                $display("FAIL %s vec%0d: got state=%0d nop_state=%0d out=%b, expected state=%0d nop_state=%0d out=%b",
                         e.tag, vec_no, bus1.state, bus0.state, act, e.s, e.s0, e.o);
            end
`ifdef MC_CTRL_PERF_EN
            if (!e.rst) begin
                checks++;
                if ((bus1.cycle_cnt !== 32'd0) || (bus1.instr_cnt !== 32'd0)) begin
                    failures++;
                    $display("FAIL %s_perf vec%0d: got cycle_cnt=%0d instr_cnt=%0d, expected 0/0",
                             e.tag, vec_no, bus1.cycle_cnt, bus1.instr_cnt);
                end
            end
`endif
            vec_no++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = OP_R; funct = FN_ADDU;
        @(posedge clk);
        #1;

        // Reset held with mem_ready high: FETCH, but every strobe forced low.
        tag = "reset";
        v(0, 1, 0, OP_R, FN_ADDU, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 0, 2'd0);
        v(0, 1, 0, OP_R, FN_ADDU, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 0, 2'd0);

        tag = "addu";
        fetch_dec(OP_R, FN_ADDU, 1);
        v(1, 1, 0, OP_R, FN_ADDU, 2, 2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 2'd0);
        v(1, 1, 0, OP_R, FN_ADDU, 7, 7, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 0, 2'd0);

        tag = "subu";
        fetch_dec(OP_R, FN_SUBU, 1);
        v(1, 1, 0, OP_R, FN_SUBU, 2, 2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd1, 0, 2'd0);
        v(1, 1, 0, OP_R, FN_SUBU, 7, 7, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd1, 0, 2'd0);

        // ori with one fetch wait cycle: no pc_we/ir_we until mem_ready.
        tag = "ori";
        v(1, 0, 0, OP_ORI, 6'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 0, 2'd0);
        fetch_dec(OP_ORI, 6'd0, 1);
        v(1, 1, 0, OP_ORI, 6'd0, 3, 3, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd2, 0, 2'd0);
        v(1, 1, 0, OP_ORI, 6'd0, 8, 8, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd1, 3'd2, 0, 2'd0);

        tag = "lui";
        fetch_dec(OP_LUI, 6'd0, 1);
        v(1, 1, 0, OP_LUI, 6'd0, 3, 3, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd3, 0, 2'd0);
        v(1, 1, 0, OP_LUI, 6'd0, 8, 8, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd1, 3'd3, 0, 2'd0);

        // lw with three wait cycles in MEM_RD: 8 cycles in total.
        tag = "lw";
        fetch_dec(OP_LW, 6'd0, 1);
        v(1, 1, 0, OP_LW, 6'd0, 4, 4, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd0, 1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            v(1, 0, 0, OP_LW, 6'd0, 5, 5, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd0, 1, 2'd0);
        end
        v(1, 1, 0, OP_LW, 6'd0, 5, 5, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd0, 1, 2'd0);
        v(1, 1, 0, OP_LW, 6'd0, 9, 9, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd0, 3'd0, 0, 2'd0);

        // sw: dm_we follows mem_ready inside MEM_WR.
        tag = "sw";
        fetch_dec(OP_SW, 6'd0, 1);
        v(1, 1, 0, OP_SW, 6'd0, 4, 4, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd0, 1, 2'd0);
        v(1, 0, 0, OP_SW, 6'd0, 6, 6, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd0, 1, 2'd0);
        v(1, 1, 0, OP_SW, 6'd0, 6, 6, 0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd1, 3'd0, 1, 2'd0);

        // beq taken; mem_ready low in DECODE must not stall it.
        tag = "beq_taken";
        fetch_dec(OP_BEQ, 6'd0, 0);
        v(1, 1, 1, OP_BEQ, 6'd0, 10, 10, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd1, 1, 2'd1);

        tag = "beq_not_taken";
        fetch_dec(OP_BEQ, 6'd0, 1);
        v(1, 1, 0, OP_BEQ, 6'd0, 10, 10, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd1, 1, 2'd1);

        tag = "j";
        fetch_dec(OP_J, 6'd0, 1);
        v(1, 1, 0, OP_J, 6'd0, 11, 11, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 2'd2);

        tag = "jal";
        fetch_dec(OP_JAL, 6'd0, 1);
        v(1, 1, 0, OP_JAL, 6'd0, 11, 11, 0, 0, 1, 0, 0, 1, 2'd2, 2'd2, 2'd0, 3'd0, 0, 2'd2);

        tag = "jr";
        fetch_dec(OP_R, FN_JR, 1);
        v(1, 1, 0, OP_R, FN_JR, 11, 11, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 2'd3);

        // nop: DECODE straight back to FETCH (checked by the next FETCH).
        tag = "nop";
        fetch_dec(OP_R, FN_NOP, 1);

        // Illegal opcode: HALT instance sticks; nop instance keeps cycling.
        tag = "illegal";
        fetch_dec(OP_ILL, 6'd0, 1);
        v(1, 1, 0, OP_ILL, 6'd0, 15, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 2'd0);
        v(1, 0, 0, OP_ILL, 6'd0, 15, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 2'd0);
        v(1, 1, 0, OP_ILL, 6'd0, 15, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 2'd0);

        tag = "reset_from_halt";
        v(0, 1, 0, OP_R, FN_ADDU, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 0, 2'd0);

        // Reset asserted in MEM_WR with mem_ready high: no write leaks.
        tag = "sw_abort";
        fetch_dec(OP_SW, 6'd0, 1);
        v(1, 1, 0, OP_SW, 6'd0, 4, 4, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd0, 1, 2'd0);
        v(1, 0, 0, OP_SW, 6'd0, 6, 6, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd0, 1, 2'd0);
        v(0, 1, 0, OP_SW, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 0, 2'd0);
        v(0, 1, 0, OP_SW, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 0, 2'd0);

        tag = "restart";
        fetch_dec(OP_R, FN_ADDU, 1);
        v(1, 1, 0, OP_R, FN_ADDU, 2, 2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 2'd0);
        v(1, 1, 0, OP_R, FN_ADDU, 7, 7, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 0, 2'd0);
        v(1, 0, 0, OP_R, FN_ADDU, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 0, 2'd0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
